// File: rtl/muldiv_iter_pkg.sv
// Shared CPU constants for the iterative multiply/divide unit: HI/LO op
// encodings, FSM state encoding and small op-decoding helpers.
package muldiv_iter_pkg;

  localparam int MULDIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic op_is_div(op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Issue-side bundle between the pipeline stage and the multiply/divide unit.
interface muldiv_iter_if
  import muldiv_iter_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH_DEFAULT
);
  logic             start;
  op_e              op;
  logic             cancel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, cancel, a, b,
    input  stall, busy, result_valid, hi, lo
  );

  modport slave (
    input  start, op, cancel, a, b,
    output stall, busy, result_valid, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step
// on the {acc, q} double-width register pair.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // NOTE: always_comb with a default for every output first, so no path can infer a latch.
  always_comb begin
    acc_next = acc;
    q_next   = q;
    addend   = q[0] ? {1'b0, m} : '0;
    sum      = {1'b0, acc} + addend;
    rem_sh   = {acc, q[WIDTH-1]};
    diff     = rem_sh - {1'b0, m};
    if (is_div) begin
      // A zero divisor never borrows, so the quotient fills with ones and the dividend lands in acc.
      if (rem_sh >= {1'b0, m}) begin
        acc_next = diff[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = rem_sh[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = sum[WIDTH:1];
      q_next   = {sum[0], q[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_iter.sv
// Iterative HI/LO multiply/divide unit: magnitudes are processed one bit per
// cycle for WIDTH cycles, then sign-corrected into hi/lo on entry to DONE.
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_iter_if.slave  bus
);
  state_e             state;
  logic               busy_q;
  logic               valid_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [CNT_W-1:0]   cnt;
  op_e                op_q;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   m;
  logic               neg_hi;
  logic               neg_lo;
  logic               div_zero;

  logic               accept;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               is_div;
  logic [WIDTH-1:0]   acc_n;
  logic [WIDTH-1:0]   q_n;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  assign sign_a = op_is_signed(bus.op) & bus.a[WIDTH-1];
  assign sign_b = op_is_signed(bus.op) & bus.b[WIDTH-1];
  assign a_mag  = sign_a ? -bus.a : bus.a;
  assign b_mag  = sign_b ? -bus.b : bus.b;
  assign is_div = op_is_div(op_q);

  assign accept           = bus.start & ~bus.cancel & (state != ST_BUSY);
  assign bus.stall        = busy_q | accept;
  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .q        (q),
    .m        (m),
    .acc_next (acc_n),
    .q_next   (q_n)
  );

  always_comb begin
    prod   = neg_lo ? -{acc_n, q_n} : {acc_n, q_n};
    fin_hi = prod[2*WIDTH-1:WIDTH];
    fin_lo = prod[WIDTH-1:0];
    if (is_div) begin
      fin_hi = neg_hi ? -acc_n : acc_n;
      fin_lo = div_zero ? '1 : (neg_lo ? -q_n : q_n);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the iteration datapath
  // (acc, q, m, op and sign flags) is deliberately not reset because it is always loaded on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      if (bus.cancel) begin
        state  <= ST_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (bus.start) begin
              state    <= ST_BUSY;
              busy_q   <= 1'b1;
              cnt      <= '0;
              op_q     <= bus.op;
              acc      <= '0;
              q        <= op_is_div(bus.op) ? a_mag : b_mag;
              m        <= op_is_div(bus.op) ? b_mag : a_mag;
              neg_lo   <= sign_a ^ sign_b;
              neg_hi   <= op_is_div(bus.op) ? sign_a : (sign_a ^ sign_b);
              div_zero <= (bus.b == '0);
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_BUSY: begin
            acc <= acc_n;
            q   <= q_n;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state   <= ST_DONE;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
              hi_q    <= fin_hi;
              lo_q    <= fin_lo;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: 32-bit and 8-bit instances, directed
// vectors with hand-computed hi/lo and expected completion cycle.
module tb_muldiv_iter;
  import muldiv_iter_pkg::*;

  typedef struct {
    logic [63:0] hi;
    logic [63:0] lo;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst32;
  logic rst8;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q32[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_iter_if #(.WIDTH(32)) b32();
  muldiv_iter_if #(.WIDTH(8))  b8();

  muldiv_iter #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst32), .bus(b32));
  muldiv_iter #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst8),  .bus(b8));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitors: every result_valid pops one expectation and checks data and timing.
  always @(negedge clk) begin
    if (b32.result_valid) begin
      if (q32.size() == 0) begin
        check("unexpected_valid32", 64'(b32.result_valid), 64'd0);
      end else begin
        exp_t e;
        e = q32.pop_front();
        check("hi32", 64'(b32.hi), e.hi);
        check("lo32", 64'(b32.lo), e.lo);
        check("latency32", 64'(cyc), 64'(e.cyc));
        check("stall_in_done32", 64'(b32.stall), 64'(b32.start & ~b32.cancel));
      end
    end
    if (b8.result_valid) begin
      if (q8.size() == 0) begin
        check("unexpected_valid8", 64'(b8.result_valid), 64'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("hi8", 64'(b8.hi), e.hi);
        check("lo8", 64'(b8.lo), e.lo);
        check("latency8", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called just after a rising edge; start is sampled at the next edge.
  task automatic issue32(input op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] eh, input logic [63:0] el, input bit expect_result);
    if (expect_result) q32.push_back('{eh, el, cyc + 33});
    b32.op = op; b32.a = a; b32.b = b; b32.start = 1'b1;
    #1 check("stall_on_start32", 64'(b32.stall), 64'd1);
    @(posedge clk); #1;
    b32.start = 1'b0;
    b32.a  = $urandom;
    b32.b  = $urandom;
    b32.op = op_e'($urandom_range(0, 3));
    check("busy_after_accept32", 64'(b32.busy), 64'd1);
  endtask

  task automatic issue8(input op_e op, input logic [7:0] a, input logic [7:0] b,
                        input logic [63:0] eh, input logic [63:0] el, input bit expect_result);
    if (expect_result) q8.push_back('{eh, el, cyc + 9});
    b8.op = op; b8.a = a; b8.b = b; b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    b8.a  = $urandom;
    b8.b  = $urandom;
    check("busy_after_accept8", 64'(b8.busy), 64'd1);
  endtask

  task automatic drain32();
    for (int i = 0; i < 200 && q32.size() != 0; i++) @(posedge clk);
    #1 check("drain32", 64'(q32.size()), 64'd0);
  endtask

  task automatic drain8();
    for (int i = 0; i < 100 && q8.size() != 0; i++) @(posedge clk);
    #1 check("drain8", 64'(q8.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst32 = 1'b1; rst8 = 1'b1;
    b32.start = 1'b0; b32.cancel = 1'b0; b32.op = OP_MULTU; b32.a = '0; b32.b = '0;
    b8.start  = 1'b0; b8.cancel  = 1'b0; b8.op  = OP_MULTU; b8.a  = '0; b8.b  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy32",  64'(b32.busy), 64'd0);
    check("rst_valid32", 64'(b32.result_valid), 64'd0);
    check("rst_stall32", 64'(b32.stall), 64'd0);
    check("rst_hi32",    64'(b32.hi), 64'd0);
    check("rst_lo32",    64'(b32.lo), 64'd0);
    check("rst_busy8",   64'(b8.busy), 64'd0);
    check("rst_hilo8",   64'({b8.hi, b8.lo}), 64'd0);
    rst32 = 1'b0; rst8 = 1'b0;
    @(posedge clk); #1;

    issue32(OP_MULT,  32'hFFFF_FFFD, 32'd7,          64'hFFFF_FFFF, 64'hFFFF_FFEB, 1); drain32();
    issue32(OP_DIV,   32'hFFFF_FFF9, 32'd2,          64'hFFFF_FFFF, 64'hFFFF_FFFD, 1); drain32();
    issue32(OP_DIVU,  32'd7,         32'd0,          64'd7,         64'hFFFF_FFFF, 1); drain32();
    issue32(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  64'd0,         64'h8000_0000, 1); drain32();
    issue32(OP_DIV,   32'hFFFF_FFFB, 32'd0,          64'hFFFF_FFFB, 64'hFFFF_FFFF, 1); drain32();
    issue32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  64'hFFFF_FFFE, 64'h0000_0001, 1); drain32();
    issue32(OP_DIV,   32'd7,         32'hFFFF_FFFE,  64'd1,         64'hFFFF_FFFD, 1); drain32();
    issue32(OP_MULT,  32'h8000_0000, 32'h8000_0000,  64'h4000_0000, 64'd0,         1); drain32();
    issue32(OP_DIVU,  32'd100,       32'd7,          64'd2,         64'd14,        1); drain32();
    check("hold_hi32", 64'(b32.hi), 64'd2);
    check("hold_lo32", 64'(b32.lo), 64'd14);

    // Back-to-back: second start issued in the DONE cycle of the first.
    issue32(OP_MULTU, 32'd5, 32'd6, 64'd0, 64'd30, 1);
    for (int i = 0; i < 100 && !b32.result_valid; i++) begin @(posedge clk); #1; end
    check("b2b_done_reached", 64'(b32.result_valid), 64'd1);
    issue32(OP_DIVU, 32'd30, 32'd4, 64'd2, 64'd7, 1);
    drain32();

    // Cancel at BUSY cycle 10: no result, hi/lo keep 2/7.
    issue32(OP_DIV, 32'd100, 32'd3, 64'd0, 64'd0, 0);
    repeat (9) @(posedge clk);
    #1 check("busy_before_cancel", 64'(b32.busy), 64'd1);
    b32.cancel = 1'b1;
    @(posedge clk); #1;
    b32.cancel = 1'b0;
    check("cancel_busy",  64'(b32.busy), 64'd0);
    check("cancel_stall", 64'(b32.stall), 64'd0);
    check("cancel_hi",    64'(b32.hi), 64'd2);
    check("cancel_lo",    64'(b32.lo), 64'd7);
    repeat (45) @(posedge clk);
    #1 check("cancel_hold_lo", 64'(b32.lo), 64'd7);

    // Cancel wins over a simultaneous start.
    b32.start = 1'b1; b32.cancel = 1'b1; b32.op = OP_MULTU; b32.a = 32'd3; b32.b = 32'd3;
    #1 check("cancel_start_stall", 64'(b32.stall), 64'd0);
    @(posedge clk); #1;
    b32.start = 1'b0; b32.cancel = 1'b0;
    check("cancel_start_busy", 64'(b32.busy), 64'd0);
    repeat (40) @(posedge clk);

    // 8-bit instance.
    #1;
    issue8(OP_MULTU, 8'hFF, 8'hFF, 64'hFE, 64'h01, 1); drain8();
    check("hold_hi8", 64'(b8.hi), 64'hFE);
    issue8(OP_MULTU, 8'd3, 8'd4, 64'd0, 64'd0, 0);
    repeat (3) @(posedge clk);
    #1 rst8 = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy8",  64'(b8.busy), 64'd0);
    check("midrst_valid8", 64'(b8.result_valid), 64'd0);
    check("midrst_stall8", 64'(b8.stall), 64'd0);
    check("midrst_hi8",    64'(b8.hi), 64'd0);
    check("midrst_lo8",    64'(b8.lo), 64'd0);
    rst8 = 1'b0;
    repeat (15) @(posedge clk);
    #1 check("midrst_busy_after8", 64'(b8.busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/muldiv_iter.md
MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits (legal values 8..64, even).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, giving the iteration counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: operation request.
REQ-006 The block SHALL have port op, input, 2 bits: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 The block SHALL have port cancel, input, 1 bit: pipeline flush, aborts any operation.
REQ-008 The block SHALL have ports a and b, input, WIDTH bits each: operands (multiplicand/dividend, multiplier/divisor).
REQ-009 The block SHALL have port stall, output, 1 bit: holds the issuing pipeline stage.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in BUSY.
REQ-011 The block SHALL have port result_valid, output, 1 bit: hi/lo valid for exactly one cycle.
REQ-012 The block SHALL have ports hi and lo, output, WIDTH bits each: product high/low half, or remainder/quotient.

Function
REQ-013 The FSM SHALL have three states, IDLE, BUSY and DONE; IDLE and DONE accept start.
REQ-014 start with cancel=0 in IDLE or DONE SHALL latch op, |a|, |b| and the result signs, clear the counter, and enter BUSY next cycle.
REQ-015 BUSY SHALL perform one radix-2 step per cycle (shift-add multiply, restoring divide) for exactly WIDTH cycles, then enter DONE.
REQ-016 Latency SHALL be WIDTH+1 cycles from the accepting edge to result_valid=1 (33 for WIDTH=32).
REQ-017 In DONE, result_valid=1 and hi/lo SHALL hold the sign-corrected result; with no new start, the next state SHALL be IDLE.
REQ-018 hi/lo SHALL hold their last valid value until the next DONE and SHALL never expose partial results.
REQ-019 stall SHALL equal busy OR (start AND NOT cancel AND state in {IDLE, DONE}), as combinational logic, and SHALL be 0 during the DONE cycle unless a new start is issued.
REQ-020 Signed ops SHALL produce a two's-complement 2*WIDTH-bit product, a quotient truncated toward zero, and a remainder carrying the dividend's sign.
REQ-021 Divide by zero SHALL give lo=all ones and hi=a, for both signed and unsigned ops, still after WIDTH+1 cycles.
REQ-022 Signed overflow (a=MIN, b=-1) SHALL give lo=MIN and hi=0.
REQ-023 cancel=1 in any state SHALL force IDLE next cycle, with no result_valid and hi/lo unchanged; cancel SHALL take precedence over a simultaneous start.
REQ-024 Operand changes on a/b/op while busy SHALL have no effect.

Reset
REQ-025 While rst=1, state SHALL go to IDLE, counter to 0, and busy, result_valid, hi and lo to 0; stall SHALL be 0 unless start is high.
REQ-026 rst mid-operation SHALL abort it exactly like cancel, with no result_valid afterwards.

Structure
REQ-027 The op encodings and the FSM state encoding SHALL live in the shared CPU package with the other ALU/HILO constants.
REQ-028 A single sub-module, muldiv_step, SHALL implement one combinational iteration (add/subtract and shift) parameterised by WIDTH.

Verification
REQ-029 The bench SHALL cover: WIDTH=32, MULT a=-3 b=7 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, result_valid for 1 cycle.
REQ-030 The bench SHALL cover: DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-031 The bench SHALL cover: DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 The bench SHALL cover: cancel at BUSY cycle 10 -> IDLE next cycle, result_valid never asserts, stall drops, hi/lo keep their prior values.
REQ-033 The bench SHALL cover: back-to-back start in DONE (MULTU 5*6, then DIVU 30/4) -> hi:lo=0:30, then hi=2 lo=7, 33 cycles apart.
REQ-034 The bench SHALL cover: WIDTH=8 instance, MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01 after 9 cycles; rst mid-op -> all outputs 0.
